// File: rtl/vga_frame_capture.sv
// Sink-side decoder for the 3-bit VGA stream: rebuilds pixel coordinates from the
// sync pulses, strobes each visible pixel, and tracks frame checksum/count/errors.
`timescale 1ns/1ps
module vga_frame_capture #(
  parameter int unsigned H_ACTIVE = 256,
  parameter int unsigned H_BACK   = 23,
  parameter int unsigned V_ACTIVE = 240,
  parameter int unsigned V_BACK   = 5,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned X_W      = $clog2(H_ACTIVE),
  parameter int unsigned Y_W      = $clog2(V_ACTIVE)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           hsync,
  input  logic           vsync,
  input  logic [2:0]     rgb,
  input  logic           err_clr,
  output logic           pix_valid,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic [2:0]     pix_rgb,
  output logic           frame_done,
  output logic [15:0]    frame_cnt,
  output logic [15:0]    frame_sum,
  output logic           line_err,
  output logic           frame_err
);

  localparam int unsigned HB_CYC = H_BACK * CLK_DIV;
  localparam int unsigned HC_W   = (HB_CYC > 1)  ? $clog2(HB_CYC)  : 1;
  localparam int unsigned LC_W   = (V_BACK > 1)  ? $clog2(V_BACK)  : 1;
  localparam int unsigned DV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HB_CYC - 1);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(V_BACK - 1);
  localparam logic [DV_W-1:0] DV_LAST = DV_W'(CLK_DIV - 1);
  localparam logic [X_W-1:0]  X_LAST  = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    WAIT_VS,
    VBACK,
    HBACK,
    ACTIVE,
    HWAIT
  } state_t;

  state_t          state, nxt_state;
  logic            r_hs, r_hs2, r_vs, r_vs2;
  logic [2:0]      r_rgb, r_rgb2;
  logic [LC_W-1:0] line_cnt, nxt_line_cnt;
  logic [HC_W-1:0] hcnt, nxt_hcnt;
  logic [DV_W-1:0] div, nxt_div;
  logic [X_W-1:0]  x, nxt_x;
  logic [Y_W-1:0]  y, nxt_y;
  logic [15:0]     sum, nxt_sum;
  logic            done_q;
  logic            emit, last_px, set_lerr, set_ferr;
  logic            hs_rise, hs_fall, vs_rise, vs_fall;

  assign hs_rise = r_hs & ~r_hs2;
  assign hs_fall = ~r_hs & r_hs2;
  assign vs_rise = r_vs & ~r_vs2;
  assign vs_fall = ~r_vs & r_vs2;

  // Sync/colour input stage; r_rgb2 aligns the colour with the FSM sampling edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hs   <= 1'b1;
      r_hs2  <= 1'b1;
      r_vs   <= 1'b1;
      r_vs2  <= 1'b1;
      r_rgb  <= 3'd0;
      r_rgb2 <= 3'd0;
    end else begin
      r_hs   <= hsync;
      r_hs2  <= r_hs;
      r_vs   <= vsync;
      r_vs2  <= r_vs;
      r_rgb  <= rgb;
      r_rgb2 <= r_rgb;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= WAIT_VS;
      line_cnt <= '0;
      hcnt     <= '0;
      div      <= '0;
      x        <= '0;
      y        <= '0;
      sum      <= 16'd0;
    end else begin
      state    <= nxt_state;
      line_cnt <= nxt_line_cnt;
      hcnt     <= nxt_hcnt;
      div      <= nxt_div;
      x        <= nxt_x;
      y        <= nxt_y;
      sum      <= nxt_sum;
    end
  end

  // Next-state logic; a vsync rise always restarts the frame and wins over hsync
  always_comb begin
    nxt_state    = state;
    nxt_line_cnt = line_cnt;
    nxt_hcnt     = hcnt;
    nxt_div      = div;
    nxt_x        = x;
    nxt_y        = y;
    nxt_sum      = sum;
    emit         = 1'b0;
    last_px      = 1'b0;
    set_lerr     = 1'b0;
    set_ferr     = 1'b0;

    if (vs_rise) begin
      nxt_state    = VBACK;
      nxt_line_cnt = '0;
      nxt_sum      = 16'd0;
    end else if (vs_fall && (state == HBACK || state == ACTIVE || state == HWAIT)) begin
      set_ferr  = 1'b1;
      nxt_state = WAIT_VS;
    end else begin
      case (state)
        WAIT_VS: ;
        VBACK: begin
          if (hs_rise) begin
            if (line_cnt == LC_LAST) begin
              nxt_state = HBACK;
              nxt_hcnt  = '0;
              nxt_y     = '0;
            end else begin
              nxt_line_cnt = line_cnt + LC_W'(1);
            end
          end
        end
        HBACK: begin
          if (hcnt == HC_LAST) begin
            nxt_state = ACTIVE;
            nxt_x     = '0;
            nxt_div   = '0;
          end else begin
            nxt_hcnt = hcnt + HC_W'(1);
          end
        end
        ACTIVE: begin
          if (hs_fall) begin
            set_lerr  = 1'b1;
            nxt_state = HWAIT;
          end else begin
            if (div == '0) begin
              emit    = 1'b1;
              nxt_sum = {sum[14:0], sum[15]} ^ {13'd0, r_rgb2};
              if (x == X_LAST) begin
                if (y == Y_LAST) begin
                  last_px   = 1'b1;
                  nxt_state = WAIT_VS;
                end else begin
                  nxt_state = HWAIT;
                end
              end else begin
                nxt_x = x + X_W'(1);
              end
            end
            nxt_div = (div == DV_LAST) ? '0 : div + DV_W'(1);
          end
        end
        HWAIT: begin
          if (hs_rise) begin
            // Only reached on the last line after a truncated final line
            if (y == Y_LAST) begin
              last_px   = 1'b1;
              nxt_state = WAIT_VS;
            end else begin
              nxt_y     = y + Y_W'(1);
              nxt_state = HBACK;
              nxt_hcnt  = '0;
            end
          end
        end
        default: nxt_state = WAIT_VS;
      endcase
    end
  end

  // Pixel strobe and frame bookkeeping outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= 3'd0;
      done_q     <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'd0;
      frame_sum  <= 16'd0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      pix_valid  <= emit;
      if (emit) begin
        pix_x   <= x;
        pix_y   <= y;
        pix_rgb <= r_rgb2;
      end
      done_q     <= last_px;
      frame_done <= done_q;
      if (done_q) begin
        frame_cnt <= frame_cnt + 16'd1;
        frame_sum <= sum;
      end
      if (set_lerr)     line_err <= 1'b1;
      else if (err_clr) line_err <= 1'b0;
      if (set_ferr)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture in a small configuration (4x3 visible, CLK_DIV=2).
`timescale 1ns/1ps
module tb_vga_frame_capture;

  localparam int unsigned HA = 4;
  localparam int unsigned HB = 2;
  localparam int unsigned VA = 3;
  localparam int unsigned VB = 1;
  localparam int unsigned CD = 2;

  logic        clk = 1'b0;
  logic        resetn, hsync, vsync, err_clr;
  logic [2:0]  rgb;
  logic        pix_valid, frame_done, line_err, frame_err;
  logic [1:0]  pix_x, pix_y;
  logic [2:0]  pix_rgb;
  logic [15:0] frame_cnt, frame_sum;

  vga_frame_capture #(
    .H_ACTIVE(HA), .H_BACK(HB), .V_ACTIVE(VA), .V_BACK(VB), .CLK_DIV(CD)
  ) dut (
    .clk(clk), .resetn(resetn), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .err_clr(err_clr), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .frame_sum(frame_sum), .line_err(line_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
    logic [2:0] rgb;
    int         cyc;
  } pix_t;

  typedef struct {
    int          short_line;
    int          abort_line;
    int          mode;
    bit          clr_same;
    bit          clr_after;
    int          exp_n;
    int          exp_done;
    logic [15:0] exp_cnt;
    logic [15:0] exp_sum;
    bit          exp_lerr;
    bit          exp_ferr;
  } vec_t;

  int   cyc = 0;
  int   done_n = 0;
  pix_t got_q[$];
  pix_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pix_valid) got_q.push_back(pix_t'{pix_x, pix_y, pix_rgb, cyc});
    if (frame_done) done_n = done_n + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame; mode 0..7 = constant colour, 8 = colour steps every pixel period
  task automatic run_frame(input int short_line, input int abort_line, input int mode,
                           input bit clr_same);
    int   t0, nvis, hi;
    bit   prev_short;
    pix_t e;
    prev_short = 1'b0;
    vsync = 1'b0; hsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    for (int l = 0; l < int'(VA); l++) begin
      for (int j = 0; j < 4; j++) begin
        hsync   = 1'b0;
        err_clr = clr_same && prev_short && (j == 1);
        @(negedge clk);
      end
      err_clr = 1'b0;
      hsync   = 1'b1;
      t0      = cyc + 1;
      nvis    = (l == short_line) ? 2 : (l == abort_line) ? 0 : int'(HA);
      hi      = (l == short_line) ? 8 : 16;
      for (int k = 0; k < nvis; k++) begin
        e.x   = 2'(k);
        e.y   = 2'(l);
        e.rgb = (mode == 8) ? 3'(k + 2) : 3'(mode);
        e.cyc = t0 + 6 + 2 * k;
        exp_q.push_back(e);
      end
      for (int i = 0; i < hi; i++) begin
        rgb = (mode == 8) ? 3'(i >> 1) : 3'(mode);
        if (l == abort_line && i == 2) vsync = 1'b0;
        @(negedge clk);
      end
      prev_short = (l == short_line);
      if (l == abort_line) break;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic compare_strobes(input string tag, input int gb, input int eb);
    int ng, ne;
    ng = got_q.size() - gb;
    ne = exp_q.size() - eb;
    check($sformatf("%s_nstrobe", tag), 64'(ng), 64'(ne));
    for (int i = 0; i < ((ng < ne) ? ng : ne); i++)
      check($sformatf("%s_pix%0d", tag, i), 64'(got_q[gb + i]), 64'(exp_q[eb + i]));
  endtask

  initial begin
    vec_t tbl[4];
    int   gb, eb, db;

    tbl[0] = '{-1, -1, 1, 1'b0, 1'b0, 12, 1, 16'd1, 16'h0FFF, 1'b0, 1'b0};
    tbl[1] = '{ 1, -1, 1, 1'b1, 1'b1, 10, 1, 16'd2, 16'h03FF, 1'b1, 1'b0};
    tbl[2] = '{-1,  1, 5, 1'b0, 1'b1,  4, 0, 16'd2, 16'h03FF, 1'b0, 1'b1};
    tbl[3] = '{-1, -1, 6, 1'b0, 1'b0, 12, 1, 16'd3, 16'h2002, 1'b0, 1'b0};

    resetn = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = 3'd0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({pix_valid, pix_x, pix_y, pix_rgb, frame_done, frame_cnt, frame_sum, line_err, frame_err}),
          64'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      gb = got_q.size(); eb = exp_q.size(); db = done_n;
      run_frame(tbl[v].short_line, tbl[v].abort_line, tbl[v].mode, tbl[v].clr_same);
      check($sformatf("v%0d_nstrobe_tbl", v), 64'(got_q.size() - gb), 64'(tbl[v].exp_n));
      compare_strobes($sformatf("v%0d", v), gb, eb);
      check($sformatf("v%0d_done", v), 64'(done_n - db), 64'(tbl[v].exp_done));
      check($sformatf("v%0d_cnt", v), 64'(frame_cnt), 64'(tbl[v].exp_cnt));
      check($sformatf("v%0d_sum", v), 64'(frame_sum), 64'(tbl[v].exp_sum));
      check($sformatf("v%0d_lerr", v), 64'(line_err), 64'(tbl[v].exp_lerr));
      check($sformatf("v%0d_ferr", v), 64'(frame_err), 64'(tbl[v].exp_ferr));
      if (tbl[v].clr_after) begin
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_clr_flags", v), 64'({line_err, frame_err}), 64'd0);
      end
    end

    // Pixel timing: colour steps each pixel period, strobes land two cycles after sampling
    gb = got_q.size(); eb = exp_q.size(); db = done_n;
    run_frame(-1, -1, 8, 1'b0);
    compare_strobes("step", gb, eb);
    check("step_done", 64'(done_n - db), 64'd1);
    check("step_cnt", 64'(frame_cnt), 64'd4);

    // Asynchronous reset mid-line, then no capture until the next vsync rise
    vsync = 1'b0; hsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    hsync = 1'b0;
    repeat (4) @(negedge clk);
    hsync = 1'b1; rgb = 3'd7;
    repeat (9) @(negedge clk);
    check("pre_reset_cnt", 64'(frame_cnt), 64'd4);
    check("pre_reset_x", 64'(pix_x), 64'd1);
    #2 resetn = 1'b0;
    #1 check("async_reset_outputs",
             64'({pix_valid, pix_x, pix_y, pix_rgb, frame_done, frame_cnt, frame_sum, line_err, frame_err}),
             64'd0);
    @(negedge clk);
    resetn = 1'b1;
    gb = got_q.size(); db = done_n;
    for (int l = 0; l < 3; l++) begin
      hsync = 1'b0;
      repeat (4) @(negedge clk);
      hsync = 1'b1;
      repeat (16) @(negedge clk);
    end
    check("post_reset_nstrobe", 64'(got_q.size() - gb), 64'd0);
    check("post_reset_done", 64'(done_n - db), 64'd0);

    // Frame counter wrap from 0xFFFF
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    check("wrap_preload", 64'(frame_cnt), 64'hFFFF);
    gb = got_q.size(); eb = exp_q.size(); db = done_n;
    run_frame(-1, -1, 3, 1'b0);
    compare_strobes("wrap", gb, eb);
    check("wrap_done", 64'(done_n - db), 64'd1);
    check("wrap_cnt", 64'(frame_cnt), 64'd0);
    check("wrap_sum", 64'(frame_sum), 64'h1001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
